// File: rtl/mod_rns_pkg.sv
// Shared types and default digit parameters for the residue-number digit sequencers.
// One package per RNS digit family; the sequencer FSM encoding lives here.
package mod_rns_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT   = 2'd2,
    COMMIT = 2'd3
  } seq_state_e;

  // Default digit: modulus 3^11 fits in 18 bits.
  localparam int RNS_DIGIT_W = 18;
  localparam int RNS_MODULUS = 177147;
  localparam int RNS_LATENCY = 2;
  localparam int RNS_PEND_W  = 4;

  // Width of the WAIT-state counter, which counts down from LATENCY-2.
  function automatic int wait_cnt_width(input int latency);
    return (latency > 2) ? $clog2(latency) : 1;
  endfunction

endpackage

// File: rtl/mod_inc_sequencer_if.sv
// Request side of the digit sequencer: increment and load handshakes.
// Valid/ready: a transfer happens on a rising clk edge where valid and ready are both high;
// a producer holds valid (and load_value) until that edge, and ready never depends on valid.
interface mod_inc_sequencer_if
  import mod_rns_pkg::*;
#(
  parameter int DATA_WIDTH = RNS_DIGIT_W
);
  logic                  inc_valid;
  logic                  inc_ready;
  logic                  load_valid;
  logic                  load_ready;
  logic [DATA_WIDTH-1:0] load_value;

  modport master (
    output inc_valid,
    output load_valid,
    output load_value,
    input  inc_ready,
    input  load_ready
  );

  modport slave (
    input  inc_valid,
    input  load_valid,
    input  load_value,
    output inc_ready,
    output load_ready
  );
endinterface

// File: rtl/mod_inc_sequencer.sv
// Issue stage for an external LATENCY-cycle modular increment unit: owns one residue digit,
// queues increment requests, drives the unit, commits results and flags wrap as a carry pulse.
module mod_inc_sequencer
  import mod_rns_pkg::*;
#(
  parameter int DATA_WIDTH = RNS_DIGIT_W,
  parameter int MODULUS    = RNS_MODULUS,
  parameter int LATENCY    = RNS_LATENCY,
  parameter int PEND_W     = RNS_PEND_W
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear,
  mod_inc_sequencer_if.slave    req,
  output logic [DATA_WIDTH-1:0] unit_a,
  output logic                  unit_cin,
  input  logic [DATA_WIDTH-1:0] unit_result,
  output logic [DATA_WIDTH-1:0] digit,
  output logic                  carry_out,
  output logic                  busy,
  output logic                  err,
  output seq_state_e            fsm_state
);

  localparam logic [PEND_W-1:0]     PEND_MAX  = '1;
  localparam logic [DATA_WIDTH-1:0] MOD_VAL   = DATA_WIDTH'(MODULUS);
  localparam int                    WAIT_W    = wait_cnt_width(LATENCY);
  localparam logic [WAIT_W-1:0]     WAIT_LOAD = WAIT_W'(LATENCY - 2);

  seq_state_e        state;
  logic [PEND_W-1:0] pend_cnt;
  logic [PEND_W-1:0] pend_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              issuing;
  logic              inc_acc;
  logic              load_acc;
  logic              load_bad;

  assign issuing = (state == ISSUE);

  // A slot frees up in the ISSUE cycle, so a full queue still accepts there (net change 0).
  assign req.inc_ready  = ~clear & ((pend_cnt != PEND_MAX) | issuing);
  assign req.load_ready = ~clear & (state == IDLE) & (pend_cnt == '0);

  assign inc_acc  = req.inc_valid & req.inc_ready;
  assign load_acc = req.load_valid & req.load_ready;
  assign load_bad = load_acc & (req.load_value >= MOD_VAL);

  // digit only moves in COMMIT/load/clear, so the unit sees a stable A operand in flight.
  assign unit_a    = digit;
  assign busy      = (state != IDLE) | (pend_cnt != '0);
  assign fsm_state = state;

  always_comb begin
    pend_nxt = pend_cnt;
    if (inc_acc) pend_nxt = pend_nxt + PEND_W'(1);
    if (issuing) pend_nxt = pend_nxt - PEND_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      pend_cnt  <= '0;
      wait_cnt  <= '0;
      digit     <= '0;
      carry_out <= 1'b0;
      err       <= 1'b0;
      unit_cin  <= 1'b0;
    end else if (clear) begin
      state     <= IDLE;
      pend_cnt  <= '0;
      wait_cnt  <= '0;
      digit     <= '0;
      carry_out <= 1'b0;
      err       <= 1'b0;
      unit_cin  <= 1'b0;
    end else begin
      pend_cnt  <= pend_nxt;
      carry_out <= 1'b0;
      err       <= 1'b0;
      unit_cin  <= 1'b0;
      case (state)
        IDLE: begin
          if (load_acc) begin
            if (load_bad) err   <= 1'b1;
            else          digit <= req.load_value;
          end else if (pend_cnt != '0) begin
            state    <= ISSUE;
            unit_cin <= 1'b1;
          end
        end
        ISSUE: begin
          state    <= WAIT;
          wait_cnt <= WAIT_LOAD;
        end
        WAIT: begin
          if (wait_cnt == '0) state <= COMMIT;
          else                wait_cnt <= wait_cnt - WAIT_W'(1);
        end
        COMMIT: begin
          // An out-of-range result is still written so the fault is visible on digit.
          digit     <= unit_result;
          carry_out <= (unit_result == '0);
          err       <= (unit_result >= MOD_VAL);
          if (pend_nxt != '0) begin
            state    <= ISSUE;
            unit_cin <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_inc_sequencer.sv
// Bench for mod_inc_sequencer with MODULUS=5, DATA_WIDTH=3, PEND_W=2 and a behavioural
// two-stage increment unit; a scoreboard holds the expected {digit, carry, err} per commit.
module tb_mod_inc_sequencer;
  import mod_rns_pkg::*;

  localparam int DW   = 3;
  localparam int MOD  = 5;
  localparam int LAT  = 2;
  localparam int PW   = 2;
  localparam int PMAX = 3;
  localparam int W    = DW + 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          clear = 1'b0;
  logic          corrupt = 1'b0;
  logic [DW-1:0] unit_a;
  logic [DW-1:0] unit_result;
  logic [DW-1:0] digit;
  logic [DW-1:0] u_s1;
  logic [DW-1:0] u_s2;
  logic          unit_cin;
  logic          carry_out;
  logic          busy;
  logic          err;
  seq_state_e    fsm_state;

  mod_inc_sequencer_if #(.DATA_WIDTH(DW)) req ();

  mod_inc_sequencer #(
    .DATA_WIDTH(DW),
    .MODULUS   (MOD),
    .LATENCY   (LAT),
    .PEND_W    (PW)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (clear),
    .req        (req),
    .unit_a     (unit_a),
    .unit_cin   (unit_cin),
    .unit_result(unit_result),
    .digit      (digit),
    .carry_out  (carry_out),
    .busy       (busy),
    .err        (err),
    .fsm_state  (fsm_state)
  );

  // clock / reset-independent environment: the increment unit sibling
  always #5 clk = ~clk;

  always @(posedge clk) begin
    u_s1 <= unit_cin ? DW'((int'(unit_a) + 1) % MOD) : unit_a;
    u_s2 <= u_s1;
  end
  assign unit_result = corrupt ? DW'(7) : u_s2;

  // scoreboard state
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int model_digit = 0;
  int err_expected = 0;
  int err_pulses = 0;
  int cmp_cnt = 0;

  task automatic check(input string name, input int act, input int req_val);
    checks++;
    if (act != req_val) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req_val, $time);
    end
  endtask

  task automatic model_inc(input bit bad_unit);
    logic [W-1:0] e;
    if (bad_unit) begin
      model_digit = 7;
      e = {DW'(7), 1'b0, 1'b1};
      err_expected++;
    end else begin
      model_digit = (model_digit + 1) % MOD;
      e = {DW'(model_digit), (model_digit == 0), 1'b0};
    end
    exp_q.push_back(e);
  endtask

  // monitor: a commit is due three cycles after the unit_cin pulse
  initial begin
    logic         is_cmp;
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (err) err_pulses++;
      if (!reset_n || clear) begin
        exp_q.delete();
        cmp_cnt = 0;
      end else begin
        is_cmp = (cmp_cnt == 1);
        if (cmp_cnt > 0) cmp_cnt--;
        if (is_cmp) begin
          if (exp_q.size() == 0) begin
            check("unexpected_commit", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("commit_digit", digit, e[W-1:2]);
            check("commit_carry", carry_out, e[1]);
            check("commit_err", err, e[0]);
          end
        end else if (carry_out) begin
          check("spurious_carry", 1, 0);
        end
        if (unit_cin) begin
          if (cmp_cnt != 0) check("cin_spacing", cmp_cnt, 0);
          cmp_cnt = 3;
        end
      end
    end
  end

  // driver tasks: each starts and ends 1 time unit after a rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 100);
    check("idle_timeout", busy, 0);
    step();
  endtask

  task automatic do_inc(input bit bad_unit);
    logic r = 1'b0;
    int   n = 0;
    req.inc_valid = 1'b1;
    while (!r && n < 60) begin
      @(negedge clk);
      r = req.inc_ready;
      step();
      n++;
    end
    req.inc_valid = 1'b0;
    if (r) model_inc(bad_unit);
    else   check("inc_accept_timeout", 0, 1);
  endtask

  task automatic do_load(input int v, input bit with_inc);
    int n = 0;
    bit bad = (v >= MOD);
    int exp_d;
    do begin
      @(negedge clk);
      n++;
    end while (!req.load_ready && n < 100);
    if (!req.load_ready) begin
      check("load_ready_timeout", 0, 1);
      step();
      return;
    end
    step();
    req.load_valid = 1'b1;
    req.load_value = DW'(v);
    req.inc_valid  = with_inc;
    @(negedge clk);
    check("load_ready_hold", req.load_ready, 1);
    if (with_inc) check("inc_ready_with_load", req.inc_ready, 1);
    step();
    req.load_valid = 1'b0;
    req.inc_valid  = 1'b0;
    if (bad) err_expected++;
    else     model_digit = v;
    exp_d = model_digit;
    if (with_inc) model_inc(1'b0);
    @(negedge clk);
    check("load_err", err, int'(bad));
    check("load_digit", digit, exp_d);
    step();
  endtask

  // holds inc_valid for n cycles starting from an idle, empty sequencer
  task automatic hold_inc(input int n);
    int   queued = 0;
    logic r;
    req.inc_valid = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      r = req.inc_ready;
      check("hold_inc_ready", r, int'((queued < PMAX) || unit_cin));
      if (r) queued++;
      if (unit_cin) queued--;
      step();
      if (r) model_inc(1'b0);
    end
    req.inc_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout t=%0t", $time);
    $fatal(1, "bench timed out");
  end

  initial begin
    int sel;
    req.inc_valid  = 1'b0;
    req.load_valid = 1'b0;
    req.load_value = '0;

    // reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_digit", digit, 0);
    check("rst_carry", carry_out, 0);
    check("rst_err", err, 0);
    check("rst_cin", unit_cin, 0);
    check("rst_busy", busy, 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("rst_inc_ready", req.inc_ready, 1);
    check("rst_load_ready", req.load_ready, 1);
    step();

    // single increment 0 -> 1
    do_inc(1'b0);
    wait_idle();
    check("single_inc_digit", digit, 1);

    // wrap 4 -> 0 with carry
    do_load(4, 1'b0);
    do_inc(1'b0);
    wait_idle();
    check("wrap_digit", digit, 0);

    // seven back-to-back increments from 0
    do_load(0, 1'b0);
    for (int i = 0; i < 7; i++) do_inc(1'b0);
    wait_idle();
    check("b2b_digit", digit, 2);

    // full queue: inc_valid held for 6 cycles
    hold_inc(6);
    wait_idle();
    check("hold_digit", digit, model_digit);

    // out-of-range load, then load + inc in the same cycle
    do_load(6, 1'b0);
    do_load(3, 1'b1);
    wait_idle();
    check("load_inc_digit", digit, 4);

    // out-of-range unit result is flagged and still written
    do_load(2, 1'b0);
    corrupt = 1'b1;
    do_inc(1'b1);
    wait_idle();
    corrupt = 1'b0;
    do_load(0, 1'b0);

    // clear during WAIT with two pending; an inc in the clear cycle is refused
    do_load(3, 1'b0);
    hold_inc(3);
    check("pre_clear_state", fsm_state, WAIT);
    clear = 1'b1;
    req.inc_valid = 1'b1;
    @(negedge clk);
    check("inc_ready_in_clear", req.inc_ready, 0);
    step();
    clear = 1'b0;
    req.inc_valid = 1'b0;
    model_digit = 0;
    @(negedge clk);
    check("clear_digit", digit, 0);
    check("clear_busy", busy, 0);
    check("clear_carry", carry_out, 0);
    step();

    // async reset during WAIT
    do_load(2, 1'b0);
    hold_inc(3);
    reset_n = 1'b0;
    @(negedge clk);
    check("async_rst_digit", digit, 0);
    check("async_rst_busy", busy, 0);
    step();
    reset_n = 1'b1;
    model_digit = 0;
    @(negedge clk);
    check("post_rst_digit", digit, 0);
    check("post_rst_busy", busy, 0);
    step();

    // randomized mix
    for (int it = 0; it < 60; it++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 5) begin
        do_inc(1'b0);
        repeat ($urandom_range(0, 3)) step();
      end else if (sel <= 7) begin
        do_load($urandom_range(0, MOD - 1), 1'($urandom_range(0, 1)));
      end else if (sel == 8) begin
        do_load($urandom_range(MOD, 7), 1'b0);
      end else begin
        wait_idle();
        hold_inc($urandom_range(1, 6));
      end
    end
    wait_idle();
    check("final_digit", digit, model_digit);

    // final report
    repeat (4) step();
    check("queue_drained", exp_q.size(), 0);
    check("err_pulse_count", err_pulses, err_expected);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
